// File: rtl/dictrl_if.sv
// dictrl_if
// Bundles the keypad event inputs and the datapath-facing control outputs
// of the dictrl keypad controller.
//
// Signals:
//   key_strb          one-cycle key event strobe (keypad -> controller)
//   key_code[4:0]     key identity, meaningful only with key_strb
//   alarm_triggered   alarm-match status from the datapath
//   ldMtens..ldSones  one-cycle time-digit load strobes
//   aMtens..aSones    one-cycle alarm-digit load strobes
//   ld_num[3:0]       digit value accompanying any load strobe
//   dicRun            1 while the clock runs
//   alarm_ena         alarm armed
//   dicSelectLEDdisp  one-cycle pulse advancing the LED digit selector
//   state[3:0]        controller FSM state, for debug
//
// Modports: slave is the controller itself, master is its environment
// (keypad scanner plus datapath).
interface dictrl_if;
    logic       key_strb;
    logic [4:0] key_code;
    logic       alarm_triggered;
    logic       ldMtens;
    logic       ldMones;
    logic       ldStens;
    logic       ldSones;
    logic       aMtens;
    logic       aMones;
    logic       aStens;
    logic       aSones;
    logic [3:0] ld_num;
    logic       dicRun;
    logic       alarm_ena;
    logic       dicSelectLEDdisp;
    logic [3:0] state;

    modport slave (
        input  key_strb, key_code, alarm_triggered,
        output ldMtens, ldMones, ldStens, ldSones,
        output aMtens, aMones, aStens, aSones,
        output ld_num, dicRun, alarm_ena, dicSelectLEDdisp, state
    );

    modport master (
        output key_strb, key_code, alarm_triggered,
        input  ldMtens, ldMones, ldStens, ldSones,
        input  aMtens, aMones, aStens, aSones,
        input  ld_num, dicRun, alarm_ena, dicSelectLEDdisp, state
    );
endinterface

// File: rtl/dictrl.sv
// dictrl
// Keypad-driven control FSM in front of the clock datapath. Turns one-cycle
// key events into digit-load strobes (time and alarm), the shared ld_num bus,
// the run/stop control, alarm arming and the LED digit-select pulse. Digits
// are range-checked here so that illegal values never reach the counters.
// Every output is registered: a key in cycle n takes effect in cycle n+1.
//
// Parameters:
//   TENS_MAX  largest legal tens digit (minutes or seconds)
//   ONES_MAX  largest legal ones digit
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  dictrl_if.slave: key inputs, alarm status and all control outputs
module dictrl #(
    parameter int unsigned TENS_MAX = 5,
    parameter int unsigned ONES_MAX = 9
) (
    input  logic     clk,
    input  logic     rst,
    dictrl_if.slave  bus
);

    // Entry states are contiguous so that (state - 1) directly indexes the
    // eight load strobes in the order ldMtens..ldSones, aMtens..aSones.
    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] T_MT = 4'd1;
    localparam logic [3:0] T_MO = 4'd2;
    localparam logic [3:0] T_ST = 4'd3;
    localparam logic [3:0] T_SO = 4'd4;
    localparam logic [3:0] A_MT = 4'd5;
    localparam logic [3:0] A_MO = 4'd6;
    localparam logic [3:0] A_ST = 4'd7;
    localparam logic [3:0] A_SO = 4'd8;

    localparam logic [4:0] KEY_LDT = 5'd16;
    localparam logic [4:0] KEY_LDA = 5'd17;
    localparam logic [4:0] KEY_NXT = 5'd18;
    localparam logic [4:0] KEY_RUN = 5'd19;
    localparam logic [4:0] KEY_AEN = 5'd20;
    localparam logic [4:0] KEY_ESC = 5'd21;

    localparam logic [3:0] TENS_LIM = 4'(TENS_MAX);
    localparam logic [3:0] ONES_LIM = 4'(ONES_MAX);

    logic [3:0] state_q, state_d;
    logic       run_q, run_d;
    logic       aen_q, aen_d;
    logic [3:0] num_q, num_d;
    logic [7:0] stb_q, stb_d;
    logic       sel_q, sel_d;

    logic       inTime;
    logic       inAlarm;
    logic       isTens;
    logic       isDigit;
    logic       digitLegal;
    logic [3:0] digitMax;
    logic [2:0] stbIdx;

    // Position decode for the current entry state and digit legality check.
    always_comb begin
        inTime     = (state_q >= T_MT) && (state_q <= T_SO);
        inAlarm    = (state_q >= A_MT) && (state_q <= A_SO);
        isTens     = (state_q == T_MT) || (state_q == T_ST) ||
                     (state_q == A_MT) || (state_q == A_ST);
        digitMax   = isTens ? TENS_LIM : ONES_LIM;
        isDigit    = (bus.key_code <= 5'd9);
        digitLegal = isDigit && (bus.key_code[3:0] <= digitMax);
        stbIdx     = 3'(state_q - 4'd1);
    end

    // Next-state and next-output computation. Strobes and the LED pulse
    // default low so they last exactly one cycle; ld_num holds otherwise.
    // A key arriving while the alarm is ringing only acknowledges it.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        aen_d   = aen_q;
        num_d   = num_q;
        stb_d   = '0;
        sel_d   = 1'b0;

        if (bus.key_strb) begin
            if (bus.alarm_triggered) begin
                aen_d   = 1'b0;
                state_d = IDLE;
                if (inTime) begin
                    run_d = 1'b1;
                end
            end else if (state_q == IDLE) begin
                case (bus.key_code)
                    KEY_LDT: begin
                        state_d = T_MT;
                        run_d   = 1'b0;
                    end
                    KEY_LDA: begin
                        state_d = A_MT;
                        aen_d   = 1'b0;
                    end
                    KEY_NXT: sel_d = 1'b1;
                    KEY_RUN: run_d = ~run_q;
                    KEY_AEN: aen_d = ~aen_q;
                    default: ;
                endcase
            end else if (inTime || inAlarm) begin
                if (digitLegal) begin
                    stb_d[stbIdx] = 1'b1;
                    num_d         = bus.key_code[3:0];
                    if (state_q == T_SO) begin
                        state_d = IDLE;
                        run_d   = 1'b1;
                    end else if (state_q == A_SO) begin
                        state_d = IDLE;
                        aen_d   = 1'b1;
                    end else begin
                        state_d = state_q + 4'd1;
                    end
                end else if (bus.key_code == KEY_ESC) begin
                    state_d = IDLE;
                    if (inTime) begin
                        run_d = 1'b1;
                    end
                end
            end else begin
                // Unreachable encodings recover to IDLE.
                state_d = IDLE;
            end
        end
    end

    // State and output registers; reset dominates any coincident key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b1;
            aen_q   <= 1'b0;
            num_q   <= 4'd0;
            stb_q   <= 8'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            aen_q   <= aen_d;
            num_q   <= num_d;
            stb_q   <= stb_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.ldMtens          = stb_q[0];
    assign bus.ldMones          = stb_q[1];
    assign bus.ldStens          = stb_q[2];
    assign bus.ldSones          = stb_q[3];
    assign bus.aMtens           = stb_q[4];
    assign bus.aMones           = stb_q[5];
    assign bus.aStens           = stb_q[6];
    assign bus.aSones           = stb_q[7];
    assign bus.ld_num           = num_q;
    assign bus.dicRun           = run_q;
    assign bus.alarm_ena        = aen_q;
    assign bus.dicSelectLEDdisp = sel_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_dictrl.sv
// tb_dictrl
// Self-checking bench for dictrl. A directed sequence walks through time and
// alarm entry, digit rejection, ESC, the idle commands, alarm acknowledge and
// mid-entry reset, followed by randomized key traffic. Each cycle's outputs
// are compared against a behavioural model that tracks the controller as a
// mode (idle / time entry / alarm entry) plus a digit position.
module tb_dictrl;

    localparam int TENS_MAX = 5;
    localparam int ONES_MAX = 9;

    localparam logic [4:0] LDT = 5'd16;
    localparam logic [4:0] LDA = 5'd17;
    localparam logic [4:0] NXT = 5'd18;
    localparam logic [4:0] RUN = 5'd19;
    localparam logic [4:0] AEN = 5'd20;
    localparam logic [4:0] ESC = 5'd21;

    logic clk;
    logic rst;

    dictrl_if bus ();

    dictrl #(.TENS_MAX(TENS_MAX), .ONES_MAX(ONES_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 time entry, 2 alarm entry.
    int         mMode;
    int         mPos;
    logic       mRun;
    logic       mAen;
    logic [3:0] mNum;
    logic [7:0] mStb;
    logic       mSel;

    int vectors;
    int miscompares;

    function automatic logic [3:0] modelState();
        if (mMode == 0) return 4'd0;
        if (mMode == 1) return 4'(1 + mPos);
        return 4'(5 + mPos);
    endfunction

    task automatic modelStep(input logic r, input logic s, input logic [4:0] code,
                             input logic trig);
        int maxDigit;
        mStb = 8'd0;
        mSel = 1'b0;
        if (r) begin
            mMode = 0; mPos = 0; mRun = 1'b1; mAen = 1'b0; mNum = 4'd0;
        end else if (s) begin
            if (trig) begin
                mAen = 1'b0;
                if (mMode == 1) mRun = 1'b1;
                mMode = 0; mPos = 0;
            end else if (mMode == 0) begin
                case (code)
                    LDT: begin mMode = 1; mPos = 0; mRun = 1'b0; end
                    LDA: begin mMode = 2; mPos = 0; mAen = 1'b0; end
                    NXT: mSel = 1'b1;
                    RUN: mRun = ~mRun;
                    AEN: mAen = ~mAen;
                    default: ;
                endcase
            end else begin
                maxDigit = (mPos % 2 == 0) ? TENS_MAX : ONES_MAX;
                if (int'(code) <= 9 && int'(code) <= maxDigit) begin
                    mStb[(mMode == 1 ? 0 : 4) + mPos] = 1'b1;
                    mNum = code[3:0];
                    mPos++;
                    if (mPos == 4) begin
                        if (mMode == 1) mRun = 1'b1;
                        else            mAen = 1'b1;
                        mMode = 0; mPos = 0;
                    end
                end else if (code == ESC) begin
                    if (mMode == 1) mRun = 1'b1;
                    mMode = 0; mPos = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [7:0] stb;
        stb = {bus.aSones, bus.aStens, bus.aMones, bus.aMtens,
               bus.ldSones, bus.ldStens, bus.ldMones, bus.ldMtens};
        check("strobes",   stb, mStb);
        check("ld_num",    {4'd0, bus.ld_num}, {4'd0, mNum});
        check("dicRun",    {7'd0, bus.dicRun}, {7'd0, mRun});
        check("alarm_ena", {7'd0, bus.alarm_ena}, {7'd0, mAen});
        check("ledSel",    {7'd0, bus.dicSelectLEDdisp}, {7'd0, mSel});
        check("state",     {4'd0, bus.state}, {4'd0, modelState()});
    endtask

    // One clock cycle: drive inputs at the falling edge, let the rising edge
    // register them, then check at the next falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [4:0] code,
                                 input logic trig);
        rst                 = r;
        bus.key_strb        = s;
        bus.key_code        = code;
        bus.alarm_triggered = trig;
        modelStep(r, s, code, trig);
        @(negedge clk);
        vectors++;
        checkOutput();
    endtask

    task automatic key(input logic [4:0] code);
        applyStimulus(1'b0, 1'b1, code, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'($urandom_range(0, 31)), 1'b0);
    endtask

    initial begin
        logic       r;
        logic       s;
        logic       t;
        logic [4:0] c;
        vectors     = 0;
        miscompares = 0;
        mMode = 0; mPos = 0; mRun = 1'b1; mAen = 1'b0; mNum = 4'd0;
        mStb = 8'd0; mSel = 1'b0;

        // Reset with a coincident key: reset values, no strobe.
        applyStimulus(1'b1, 1'b1, LDT, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);

        // Time entry 1,2,3,4 back to back.
        key(LDT); key(5'd1); key(5'd2); key(5'd3); key(5'd4);
        idleCycle();

        // Illegal tens digit rejected, then legal 5; leave with ESC.
        key(LDT); key(5'd7); key(5'd5);
        key(LDA); key(NXT);
        key(5'd9); key(5'd6); key(5'd5);
        key(ESC);

        // Alarm entry 0,1,0,0 with the clock running throughout.
        key(LDA); key(5'd0); key(5'd1); key(5'd0); key(5'd0);
        idleCycle();

        // Time entry aborted after one digit.
        key(LDT); key(5'd2); key(ESC);
        idleCycle(); idleCycle();

        // Idle commands and ignored keys.
        key(NXT); idleCycle();
        key(RUN); key(RUN);
        key(AEN); key(AEN);
        key(5'd3); key(ESC); key(5'd12); key(5'd31);

        // Alarm acknowledge in idle and during entry.
        if (!mAen) key(AEN);
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1);
        key(AEN);
        key(LDT); key(5'd1);
        applyStimulus(1'b0, 1'b1, 5'd2, 1'b1);

        // Reset in A_MO with a coincident digit.
        key(LDA); key(5'd4);
        applyStimulus(1'b1, 1'b1, 5'd2, 1'b0);
        idleCycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: c = 5'($urandom_range(0, 9));
                5, 6, 7, 8:    c = 5'($urandom_range(16, 21));
                default:       c = 5'($urandom_range(0, 31));
            endcase
            applyStimulus(r, s, c, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
